// File: rtl/dds_pkg.sv
// Shared DDS definitions: default widths, slot phase encoding and the
// accumulator-to-table-index helper used by the datapath and register decoder.
package dds_pkg;

    localparam int unsigned DDS_FCW_W      = 24;
    localparam int unsigned DDS_LUT_AW     = 10;
    localparam int unsigned DDS_SAMPLE_W   = 16;

    // Widest accumulator / table index the helper below can serve.
    localparam int unsigned DDS_ACCU_MAX_W = 32;
    localparam int unsigned DDS_LUT_MAX_W  = 16;

    typedef logic [DDS_ACCU_MAX_W-1:0] accu_max_t;
    typedef logic [DDS_LUT_MAX_W-1:0]  lut_max_t;

    // Activity within one channel slot.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT,
        PH_CAPTURE,
        PH_IDLE
    } slot_phase_e;

    // Top bits of an accumulator. Callers left-align their accumulator into
    // accu_max_t and keep the top LUT_AW bits of the result, so one function
    // serves every FCW_W / LUT_AW combination.
    function automatic lut_max_t lut_index(input accu_max_t accu);
        return lut_max_t'(accu >> (DDS_ACCU_MAX_W - DDS_LUT_MAX_W));
    endfunction

endpackage

// File: rtl/dds_channel_sched_accu_bank.sv
// dds_accu_bank: per-channel frequency words, phase accumulators and
// pending-clear flags, with a CPU write port and one addressed step port.
module dds_accu_bank
    import dds_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned FCW_W    = DDS_FCW_W,
    localparam int unsigned CW      = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [FCW_W-1:0]    wr_fcw,
    input  logic [CHANNELS-1:0] clr_req,
    input  logic                step_en,
    input  logic [CW-1:0]       step_ch,
    input  logic                step_keep,
    output logic [FCW_W-1:0]    cur_accu
);

    logic [FCW_W-1:0]    fcw  [CHANNELS];
    logic [FCW_W-1:0]    accu [CHANNELS];
    logic [CHANNELS-1:0] clr_pend;

    // Accumulator of the channel being stepped, used for address issue.
    assign cur_accu = accu[step_ch];

    // Frequency word register file; the last write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                fcw[i] <= '0;
            end
        end else if (wr_en) begin
            fcw[wr_ch] <= wr_fcw;
        end
    end

    // Accumulator step and clear bookkeeping. A clear request arriving on the
    // step cycle of its own channel is consumed by that step.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                accu[i] <= '0;
            end
            clr_pend <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (clr_req[i]) begin
                    clr_pend[i] <= 1'b1;
                end
            end
            if (step_en) begin
                if (!step_keep || clr_pend[step_ch] || clr_req[step_ch]) begin
                    accu[step_ch] <= '0;
                end else begin
                    accu[step_ch] <= accu[step_ch] + fcw[step_ch];
                end
                clr_pend[step_ch] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dds_channel_sched.sv
// dds_channel_sched: visits CHANNELS DDS voices round-robin in fixed slots,
// issuing one sine-table read per slot and returning one tagged sample.
module dds_channel_sched
    import dds_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned FCW_W       = DDS_FCW_W,
    parameter int unsigned LUT_AW      = DDS_LUT_AW,
    parameter int unsigned SAMPLE_W    = DDS_SAMPLE_W,
    parameter int unsigned SLOT_CYCLES = 3,
    localparam int unsigned CW         = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [FCW_W-1:0]    wr_fcw,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] ph_clr,
    output logic [LUT_AW-1:0]   lut_addr,
    input  logic [SAMPLE_W-1:0] lut_data,
    output logic [SAMPLE_W-1:0] sample,
    output logic [CW-1:0]       sample_ch,
    output logic                sample_stb,
    output logic                frame_stb
);

    localparam int unsigned     PH_W    = $clog2(SLOT_CYCLES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]   CH_LAST = CW'(CHANNELS - 1);

    logic [PH_W-1:0]   ph, ph_nxt;
    logic [CW-1:0]     ch, ch_nxt;
    slot_phase_e       phase;
    logic              frame_end;
    logic              issue;
    logic              en_now;
    logic              en_q;
    logic [FCW_W-1:0]  cur_accu;
    accu_max_t         accu_aligned;
    logic [LUT_AW-1:0] issue_addr;

    assign issue  = (phase == PH_ISSUE);
    assign en_now = ch_en[ch];

    assign accu_aligned = accu_max_t'(cur_accu) << (DDS_ACCU_MAX_W - FCW_W);
    assign issue_addr   = LUT_AW'(lut_index(accu_aligned) >> (DDS_LUT_MAX_W - LUT_AW));

    dds_accu_bank #(
        .CHANNELS (CHANNELS),
        .FCW_W    (FCW_W)
    ) u_accu_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_fcw    (wr_fcw),
        .clr_req   (ph_clr),
        .step_en   (issue),
        .step_ch   (ch),
        .step_keep (en_now),
        .cur_accu  (cur_accu)
    );

    // Slot/phase counter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ph <= '0;
            ch <= '0;
        end else begin
            ph <= ph_nxt;
            ch <= ch_nxt;
        end
    end

    // Next slot/phase, phase decode and end-of-frame detection.
    always_comb begin
        ph_nxt    = ph + PH_W'(1);
        ch_nxt    = ch;
        frame_end = 1'b0;
        phase     = PH_IDLE;
        if (ph == PH_LAST) begin
            ph_nxt    = '0;
            // CHANNELS is a power of two, so the increment wraps on its own.
            ch_nxt    = ch + CW'(1);
            frame_end = (ch == CH_LAST);
        end
        if (ph == PH_W'(0)) begin
            phase = PH_ISSUE;
        end else if (ph == PH_W'(1)) begin
            phase = PH_WAIT;
        end else if (ph == PH_W'(2)) begin
            phase = PH_CAPTURE;
        end
    end

    // Address issue, sample capture and strobe generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            lut_addr   <= '0;
            sample     <= '0;
            sample_ch  <= '0;
            sample_stb <= 1'b0;
            frame_stb  <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            frame_stb  <= frame_end;
            if (issue) begin
                en_q <= en_now;
                if (en_now) begin
                    lut_addr <= issue_addr;
                end
            end
            if (phase == PH_CAPTURE && en_q) begin
                sample     <= lut_data;
                sample_ch  <= ch;
                sample_stb <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dds_channel_sched.sv
// Testbench for dds_channel_sched: directed vector table, hand-written
// corner sequences, and randomized traffic against a cycle-count reference.
module tb_dds_channel_sched;

    localparam int unsigned CH = 4;
    localparam int unsigned FW = 24;
    localparam int unsigned AW = 10;
    localparam int unsigned SW = 16;
    localparam int unsigned SC = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [FW-1:0] wr_fcw;
    logic [CH-1:0] ch_en;
    logic [CH-1:0] ph_clr;
    logic [AW-1:0] lut_addr;
    logic [SW-1:0] lut_data;
    logic [SW-1:0] sample;
    logic [1:0]    sample_ch;
    logic          sample_stb;
    logic          frame_stb;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        chk_on = 1'b0;

    always #5 clk = ~clk;

    dds_channel_sched #(
        .CHANNELS    (CH),
        .FCW_W       (FW),
        .LUT_AW      (AW),
        .SAMPLE_W    (SW),
        .SLOT_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_fcw     (wr_fcw),
        .ch_en      (ch_en),
        .ph_clr     (ph_clr),
        .lut_addr   (lut_addr),
        .lut_data   (lut_data),
        .sample     (sample),
        .sample_ch  (sample_ch),
        .sample_stb (sample_stb),
        .frame_stb  (frame_stb)
    );

    // Sine ROM stand-in: arbitrary but address-dependent contents.
    function automatic logic [SW-1:0] rom(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {22'd0, a} * 32'd40503 + 32'h1234;
        return x[23:8];
    endfunction

    always @(posedge clk) lut_data <= rom(lut_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a clock count since reset gives slot and phase by division.
    logic [FW-1:0] m_fcw  [CH];
    logic [FW-1:0] m_accu [CH];
    logic          m_clr  [CH];
    int unsigned   t;
    int unsigned   m_ph, m_c;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [SW-1:0] m_sample;
    logic [1:0]    m_sch;
    logic          m_stb, m_frame;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                m_fcw[i] = '0; m_accu[i] = '0; m_clr[i] = 1'b0;
            end
            t = 0; m_en = 1'b0; m_addr = '0; m_sample = '0;
            m_sch = '0; m_stb = 1'b0; m_frame = 1'b0;
        end else begin
            m_ph    = t % SC;
            m_c     = (t / SC) % CH;
            m_stb   = 1'b0;
            m_frame = (m_ph == SC - 1) && (m_c == CH - 1);
            if (m_ph == 0) begin
                m_en = ch_en[m_c];
                if (m_en) m_addr = m_accu[m_c][FW-1 -: AW];
                if (!m_en || m_clr[m_c] || ph_clr[m_c]) m_accu[m_c] = '0;
                else m_accu[m_c] = m_accu[m_c] + m_fcw[m_c];
                m_clr[m_c] = 1'b0;
            end
            if (m_ph == 2 && m_en) begin
                m_sample = rom(m_addr);
                m_sch    = 2'(m_c);
                m_stb    = 1'b1;
            end
            for (int i = 0; i < CH; i++)
                if (ph_clr[i] && !(m_ph == 0 && i == int'(m_c))) m_clr[i] = 1'b1;
            if (wr_en) m_fcw[wr_ch] = wr_fcw;
            t++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("lut_addr", 32'(lut_addr), 32'(m_addr));
            chk("sample", 32'(sample), 32'(m_sample));
            chk("sample_ch", 32'(sample_ch), 32'(m_sch));
            chk("sample_stb", 32'(sample_stb), 32'(m_stb));
            chk("frame_stb", 32'(frame_stb), 32'(m_frame));
        end
    end

    // Advance to the negedge following the j-th clock since reset release.
    task automatic at_edge(input int unsigned j);
        int unsigned guard;
        guard = 0;
        while (t < j && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("sync", 32'(t), 32'(j));
    endtask

    task automatic restart(input logic [CH-1:0] en);
        reset = 1'b1; wr_en = 1'b0; ph_clr = '0; ch_en = en;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int unsigned   ch;
        logic [FW-1:0] fcw;
        int unsigned   frame;
        logic [AW-1:0] exp_addr;
    } tv_t;

    tv_t tv [8];
    int unsigned j;

    initial begin
        tv[0] = '{0, 24'h004000, 1, 10'd0};
        tv[1] = '{0, 24'h004000, 4, 10'd3};
        tv[2] = '{1, 24'h008000, 3, 10'd4};
        tv[3] = '{2, 24'hFFC000, 2, 10'd1023};
        tv[4] = '{2, 24'hFFC000, 3, 10'd1022};
        tv[5] = '{3, 24'h010000, 5, 10'd16};
        tv[6] = '{1, 24'h7FFFFF, 3, 10'd1023};
        tv[7] = '{3, 24'h00C000, 4, 10'd9};

        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_fcw = '0; ch_en = '0; ph_clr = '0;
        @(negedge clk);
        chk_on = 1'b1;

        // Reset state and first strobe after the channel-0 slot.
        ch_en = 4'hF;
        repeat (5) @(negedge clk);
        chk("rst_lut_addr", 32'(lut_addr), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_sample_ch", 32'(sample_ch), 32'd0);
        chk("rst_sample_stb", 32'(sample_stb), 32'd0);
        chk("rst_frame_stb", 32'(frame_stb), 32'd0);
        reset = 1'b0;
        at_edge(3);
        chk("first_stb", 32'(sample_stb), 32'd1);
        chk("first_ch", 32'(sample_ch), 32'd0);
        chk("first_sample", 32'(sample), 32'(rom(10'd0)));

        // Single-voice table: channel enabled from frame 1, fcw written first.
        for (int i = 0; i < 8; i++) begin
            restart('0);
            wr_en = 1'b1; wr_ch = 2'(tv[i].ch); wr_fcw = tv[i].fcw;
            at_edge(1);
            wr_en = 1'b0;
            at_edge(11);
            ch_en = 4'(1 << tv[i].ch);
            j = 12 * tv[i].frame + 3 * tv[i].ch + 1;
            at_edge(j);
            chk("tv_addr", 32'(lut_addr), 32'(tv[i].exp_addr));
            at_edge(j + 2);
            chk("tv_stb", 32'(sample_stb), 32'd1);
            chk("tv_ch", 32'(sample_ch), 32'(tv[i].ch));
            chk("tv_sample", 32'(sample), 32'(rom(tv[i].exp_addr)));
        end

        // Write to fcw[1] on channel 1's ISSUE cycle.
        restart(4'b0010);
        wr_en = 1'b1; wr_ch = 2'd1; wr_fcw = 24'h004000;
        at_edge(1); wr_en = 1'b0;
        at_edge(15); wr_en = 1'b1; wr_fcw = 24'h00C000;
        at_edge(16); wr_en = 1'b0;
        chk("coll_addr_f1", 32'(lut_addr), 32'd1);
        at_edge(28); chk("coll_addr_f2", 32'(lut_addr), 32'd2);
        at_edge(40); chk("coll_addr_f3", 32'(lut_addr), 32'd5);

        // Phase clear mid-frame, then a clear landing on the ISSUE cycle.
        restart(4'b0100);
        wr_en = 1'b1; wr_ch = 2'd2; wr_fcw = 24'h004000;
        at_edge(1); wr_en = 1'b0;
        at_edge(21); ph_clr = 4'b0100;
        at_edge(22); ph_clr = '0;
        at_edge(31); chk("clr_pre", 32'(lut_addr), 32'd2);
        at_edge(43); chk("clr_zero", 32'(lut_addr), 32'd0);
        at_edge(55); chk("clr_resume", 32'(lut_addr), 32'd1);
        at_edge(66); ph_clr = 4'b0100;
        at_edge(67); ph_clr = '0;
        chk("clr_issue_pre", 32'(lut_addr), 32'd2);
        at_edge(79); chk("clr_issue_zero", 32'(lut_addr), 32'd0);

        // Disable channel 3 mid-slot.
        restart(4'b1000);
        wr_en = 1'b1; wr_ch = 2'd3; wr_fcw = 24'h004000;
        at_edge(1); wr_en = 1'b0;
        at_edge(22); ch_en = '0;
        at_edge(24);
        chk("dis_cur_stb", 32'(sample_stb), 32'd1);
        chk("dis_cur_ch", 32'(sample_ch), 32'd3);
        at_edge(34); chk("dis_addr_hold", 32'(lut_addr), 32'd1);
        at_edge(36); chk("dis_no_stb", 32'(sample_stb), 32'd0);
        at_edge(40); ch_en = 4'b1000;
        at_edge(46); chk("dis_accu_zero", 32'(lut_addr), 32'd0);

        // Reset asserted during WAIT of channel 0.
        restart(4'hF);
        at_edge(1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_stb_hold", 32'(sample_stb), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_no_stb", 32'(sample_stb), 32'd0);
        at_edge(3); chk("rstw_new_stb", 32'(sample_stb), 32'd1);

        // Randomized traffic, continuously checked against the reference.
        for (int n = 0; n < 1500; n++) begin
            wr_en  = ($urandom_range(0, 3) == 0);
            wr_ch  = 2'($urandom_range(0, 3));
            wr_fcw = ($urandom_range(0, 1) == 1) ? FW'($urandom)
                                                 : FW'($urandom_range(0, 4)) << 14;
            if ($urandom_range(0, 15) == 0) ch_en = ch_en ^ 4'(1 << $urandom_range(0, 3));
            ph_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
            reset  = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        reset = 1'b0; wr_en = 1'b0; ph_clr = '0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
